// File: rtl/adsr_pkg.sv
// adsr_pkg: shared ADSR state encoding, envelope ceiling and sustain scaling
package adsr_pkg;

    typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} adsr_state_t;

    function automatic logic [63:0] max_envelope(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    // Percent above 100 clamps to 100; the 64-bit product cannot overflow for widths up to 57
    function automatic logic [63:0] sustain_scale(input logic [63:0] max_level, input logic [6:0] percent);
        logic [63:0] p;
        p = percent > 7'd100 ? 64'd100 : 64'(percent);
        return (max_level * p) / 64'd100;
    endfunction

endpackage

// File: rtl/adsr_voice_next.sv
// adsr_voice_next: combinational next state and level for the voice in the current sweep slot
module adsr_voice_next
    import adsr_pkg::*;
#(
    parameter int EW = 32
) (
    input  adsr_state_t   state,
    input  logic [EW-1:0] level,
    input  logic          gate,
    input  logic          rise,
    input  logic [EW-1:0] attack_step,
    input  logic [EW-1:0] decay_step,
    input  logic [EW-1:0] release_step,
    input  logic [EW-1:0] sustain_level,
    output adsr_state_t   next_state,
    output logic [EW-1:0] next_level
);
    localparam logic [EW-1:0] MAX_ENV = EW'(max_envelope(EW));

    logic [EW-1:0] attacked;
    logic          attack_full;
    logic          decay_done;
    logic          release_done;

    always_comb begin
        attack_full  = MAX_ENV - level <= attack_step;
        attacked     = attack_full ? MAX_ENV : level + attack_step;
        decay_done   = level <= sustain_level || level - sustain_level <= decay_step;
        release_done = level <= release_step;
        next_state   = state;
        next_level   = level;
        if (!gate && (state == ATTACK || state == DECAY || state == SUSTAIN)) begin
            next_state = RELEASE;
        end else if (rise || state == ATTACK) begin
            // A retrigger climbs from the current level so the output never jumps
            next_state = attack_full ? DECAY : ATTACK;
            next_level = attacked;
        end else begin
            case (state)
                DECAY: begin
                    next_state = decay_done ? SUSTAIN : DECAY;
                    next_level = decay_done ? sustain_level : level - decay_step;
                end
                SUSTAIN: next_level = sustain_level;
                RELEASE: begin
                    next_state = release_done ? IDLE : RELEASE;
                    next_level = release_done ? '0 : level - release_step;
                end
                default: next_level = '0;
            endcase
        end
    end

endmodule

// File: rtl/clk_divider.sv
// clk_divider: one-cycle tick every DIVIDER clocks, restarted by reset
module clk_divider #(
    parameter int DIVIDER = 100_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CW = DIVIDER > 1 ? $clog2(DIVIDER) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIVIDER - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else
            count <= count == LAST ? '0 : count + CW'(1);
    end

    assign tick = count == LAST;

endmodule

// File: rtl/poly_adsr_envelope.sv
// poly_adsr_envelope: NUM_VOICES linear ADSR envelopes sharing one setting,
// updated one voice per clock in a sweep launched by each divider tick
module poly_adsr_envelope
    import adsr_pkg::*;
#(
    parameter int NUM_VOICES     = 8,
    parameter int RATE_WIDTH     = 16,
    parameter int ENVELOPE_WIDTH = 32,
    parameter int TICK_DIVIDER   = 100_000
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [RATE_WIDTH-1:0]                attack_time,
    input  logic [RATE_WIDTH-1:0]                decay_time,
    input  logic [6:0]                           sustain_percent,
    input  logic [RATE_WIDTH-1:0]                release_time,
    input  logic [NUM_VOICES-1:0]                gate,
    output logic [NUM_VOICES*ENVELOPE_WIDTH-1:0] env_out,
    output logic [NUM_VOICES-1:0]                voice_active,
    output logic                                 busy,
    output logic                                 frame_done
);
    localparam int EW = ENVELOPE_WIDTH;
    localparam int IW = NUM_VOICES > 1 ? $clog2(NUM_VOICES) : 1;
    localparam logic [EW-1:0] MAX_ENV = EW'(max_envelope(EW));
    localparam logic [IW-1:0] LAST = IW'(NUM_VOICES - 1);

    if (TICK_DIVIDER <= NUM_VOICES + 1) begin : g_bad_divider
        $error("TICK_DIVIDER must exceed NUM_VOICES+1");
    end

    logic                  tick;
    logic [IW-1:0]         idx;
    logic [NUM_VOICES-1:0] gate_prev;
    logic [NUM_VOICES-1:0] rise_now;
    logic [NUM_VOICES-1:0] rise_pending;
    logic [EW-1:0]         level_mem [NUM_VOICES];
    adsr_state_t           state_mem [NUM_VOICES];
    logic [EW-1:0]         sustain_c, attack_c, decay_c, release_c;
    logic [EW-1:0]         sustain_q, attack_q, decay_q, release_q;
    adsr_state_t           next_state;
    logic [EW-1:0]         next_level;

    clk_divider #(.DIVIDER(TICK_DIVIDER)) u_div (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_comb begin
        sustain_c = EW'(sustain_scale(64'(MAX_ENV), sustain_percent));
        attack_c  = attack_time  == '0 ? MAX_ENV : MAX_ENV / EW'(attack_time);
        decay_c   = decay_time   == '0 ? MAX_ENV : (MAX_ENV - sustain_c) / EW'(decay_time);
        release_c = release_time == '0 ? MAX_ENV : MAX_ENV / EW'(release_time);
    end

    assign rise_now = gate & ~gate_prev;

    adsr_voice_next #(.EW(EW)) u_next (
        .state         (state_mem[idx]),
        .level         (level_mem[idx]),
        .gate          (gate[idx]),
        .rise          (rise_pending[idx] | rise_now[idx]),
        .attack_step   (attack_q),
        .decay_step    (decay_q),
        .release_step  (release_q),
        .sustain_level (sustain_q),
        .next_state    (next_state),
        .next_level    (next_level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                level_mem[v] <= '0;
                state_mem[v] <= IDLE;
            end
            gate_prev    <= '0;
            rise_pending <= '0;
            idx          <= '0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            sustain_q    <= '0;
            attack_q     <= '0;
            decay_q      <= '0;
            release_q    <= '0;
        end else begin
            gate_prev    <= gate;
            rise_pending <= rise_pending | rise_now;
            frame_done   <= 1'b0;
            if (tick) begin
                // Settings freeze here so every voice in the sweep sees the same values
                sustain_q <= sustain_c;
                attack_q  <= attack_c;
                decay_q   <= decay_c;
                release_q <= release_c;
                idx       <= '0;
                busy      <= 1'b1;
            end else if (busy) begin
                level_mem[idx]    <= next_level;
                state_mem[idx]    <= next_state;
                rise_pending[idx] <= 1'b0;
                busy              <= idx != LAST;
                frame_done        <= idx == LAST;
                idx               <= idx == LAST ? idx : idx + IW'(1);
            end
        end
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_out
        assign env_out[v*EW +: EW] = level_mem[v];
        assign voice_active[v]     = state_mem[v] != IDLE;
    end

endmodule

// File: tb/tb_poly_adsr_envelope.sv
// tb_poly_adsr_envelope: directed and randomized sweeps checked against a per-tick ADSR model
module tb_poly_adsr_envelope;
    localparam int NV  = 4;
    localparam int EW  = 32;
    localparam int RW  = 16;
    localparam int DIV = 16;
    localparam longint MX = 64'h7FFF_FFFF;
    localparam int S_IDLE = 0, S_ATT = 1, S_DEC = 2, S_SUS = 3, S_REL = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [RW-1:0] attack_time = '0;
    logic [RW-1:0] decay_time = '0;
    logic [RW-1:0] release_time = '0;
    logic [6:0]    sustain_percent = '0;
    logic [NV-1:0] gate = '0;
    logic [NV*EW-1:0] env_out;
    logic [NV-1:0] voice_active;
    logic          busy;
    logic          frame_done;

    int checks = 0;
    int failures = 0;
    longint m_lvl [NV];
    int     m_st [NV];
    logic [NV-1:0] m_rise = '0;

    always #5 clk = ~clk;

    poly_adsr_envelope #(
        .NUM_VOICES(NV), .RATE_WIDTH(RW), .ENVELOPE_WIDTH(EW), .TICK_DIVIDER(DIV)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .attack_time     (attack_time),
        .decay_time      (decay_time),
        .sustain_percent (sustain_percent),
        .release_time    (release_time),
        .gate            (gate),
        .env_out         (env_out),
        .voice_active    (voice_active),
        .busy            (busy),
        .frame_done      (frame_done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_gate(input logic [NV-1:0] g);
        m_rise |= g & ~gate;
        gate = g;
    endtask

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            m_lvl[v] = 0;
            m_st[v]  = S_IDLE;
        end
        m_rise = '0;
    endtask

    // One tick of every voice, written as clamped min/max arithmetic on the ADSR rules
    task automatic model_sweep();
        longint pct = sustain_percent > 100 ? 100 : longint'(sustain_percent);
        longint sus = MX * pct / 100;
        longint as  = attack_time  == 0 ? MX : MX / longint'(attack_time);
        longint ds  = decay_time   == 0 ? MX : (MX - sus) / longint'(decay_time);
        longint rs  = release_time == 0 ? MX : MX / longint'(release_time);
        for (int v = 0; v < NV; v++) begin
            if (!gate[v] && (m_st[v] == S_ATT || m_st[v] == S_DEC || m_st[v] == S_SUS)) begin
                m_st[v] = S_REL;
            end else if (m_rise[v] || m_st[v] == S_ATT) begin
                m_lvl[v] = m_lvl[v] + as > MX ? MX : m_lvl[v] + as;
                m_st[v]  = m_lvl[v] == MX ? S_DEC : S_ATT;
            end else if (m_st[v] == S_DEC) begin
                m_lvl[v] = m_lvl[v] - ds < sus ? sus : m_lvl[v] - ds;
                if (m_lvl[v] == sus) m_st[v] = S_SUS;
            end else if (m_st[v] == S_SUS) begin
                m_lvl[v] = sus;
            end else if (m_st[v] == S_REL) begin
                m_lvl[v] = m_lvl[v] - rs < 0 ? 0 : m_lvl[v] - rs;
                if (m_lvl[v] == 0) m_st[v] = S_IDLE;
            end else begin
                m_lvl[v] = 0;
            end
        end
        m_rise = '0;
    endtask

    task automatic compare_all(input string tag);
        logic [NV-1:0] act;
        for (int v = 0; v < NV; v++) begin
            act[v] = m_st[v] != S_IDLE;
            chk($sformatf("%s_env%0d", tag, v), 64'(env_out[v*EW +: EW]), m_lvl[v]);
        end
        chk({tag, "_active"}, 64'(voice_active), 64'(act));
    endtask

    task automatic run_sweep(input string tag);
        int n = 0;
        int w = 0;
        while (busy !== 1'b1 && n < 4 * DIV) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_start"}, 64'(busy), 64'd1);
        while (busy === 1'b1 && w < 4 * NV) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_busyw"}, 64'(w), 64'(NV));
        chk({tag, "_fdone"}, 64'(frame_done), 64'd1);
        model_sweep();
        compare_all(tag);
    endtask

    initial begin
        logic [31:0] att_exp [5];
        int n;
        att_exp = '{32'h1FFF_FFFF, 32'h3FFF_FFFE, 32'h5FFF_FFFD, 32'h7FFF_FFFC, 32'h7FFF_FFFF};
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_env", 64'(env_out), 64'd0);
        chk("rst_active", 64'(voice_active), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_fdone", 64'(frame_done), 64'd0);
        rst = 1'b0;

        attack_time = 4; decay_time = 8; sustain_percent = 60; release_time = 0;
        set_gate(4'b0001);
        for (int t = 0; t < 5; t++) begin
            run_sweep($sformatf("att%0d", t + 1));
            chk($sformatf("att%0d_v0", t + 1), 64'(env_out[0 +: EW]), 64'(att_exp[t]));
            chk($sformatf("att%0d_v123", t + 1), 64'(env_out[NV*EW-1:EW]), 64'd0);
            chk($sformatf("att%0d_act", t + 1), 64'(voice_active), 64'b0001);
        end
        set_gate(4'b0000);
        run_sweep("att_rel");
        run_sweep("att_idle");

        attack_time = 0; decay_time = 0; release_time = 0; sustain_percent = 50;
        set_gate(4'b0010);
        run_sweep("zt1");
        chk("zt1_v1", 64'(env_out[EW +: EW]), 64'h7FFF_FFFF);
        run_sweep("zt2");
        chk("zt2_v1", 64'(env_out[EW +: EW]), 64'h3FFF_FFFF);
        set_gate(4'b0000);
        run_sweep("zt3");
        chk("zt3_v1", 64'(env_out[EW +: EW]), 64'h3FFF_FFFF);
        chk("zt3_act", 64'(voice_active), 64'b0010);
        run_sweep("zt4");
        chk("zt4_v1", 64'(env_out[EW +: EW]), 64'd0);
        chk("zt4_act", 64'(voice_active), 64'd0);

        sustain_percent = 127;
        set_gate(4'b0001);
        run_sweep("clamp1");
        run_sweep("clamp2");
        chk("clamp_sus", 64'(env_out[0 +: EW]), 64'h7FFF_FFFF);
        set_gate(4'b0000);
        run_sweep("clamp3");
        run_sweep("clamp4");

        attack_time = 10; release_time = 4; sustain_percent = 50;
        set_gate(4'b0001);
        repeat (3) run_sweep("mid_att");
        chk("mid_att_v0", 64'(env_out[0 +: EW]), 64'h2666_6664);
        set_gate(4'b0000);
        run_sweep("mid_rel1");
        chk("mid_rel1_v0", 64'(env_out[0 +: EW]), 64'h2666_6664);
        run_sweep("mid_rel2");
        chk("mid_rel2_v0", 64'(env_out[0 +: EW]), 64'h0666_6665);
        run_sweep("mid_rel3");
        chk("mid_rel3_v0", 64'(env_out[0 +: EW]), 64'd0);

        repeat (2) @(negedge clk);
        set_gate(4'b1000);
        repeat (2) @(negedge clk);
        set_gate(4'b0000);
        run_sweep("pulse1");
        chk("pulse1_v3", 64'(env_out[3*EW +: EW]), 64'h0CCC_CCCC);
        chk("pulse1_act", 64'(voice_active), 64'b1000);
        run_sweep("pulse2");
        chk("pulse2_v3", 64'(env_out[3*EW +: EW]), 64'h0CCC_CCCC);
        run_sweep("pulse3");

        for (int r = 0; r < 24; r++) begin
            attack_time = RW'($urandom_range(0, 6));
            decay_time = RW'($urandom_range(0, 6));
            release_time = RW'($urandom_range(0, 6));
            sustain_percent = 7'($urandom_range(0, 127));
            set_gate(NV'($urandom_range(0, 15)));
            if (r % 5 == 4) begin
                @(negedge clk);
                set_gate(gate ^ NV'($urandom_range(0, 15)));
            end
            run_sweep($sformatf("rnd%0d", r));
        end

        attack_time = 4;
        set_gate(4'b0011);
        run_sweep("pre_rst");
        n = 0;
        while (busy !== 1'b1 && n < 4 * DIV) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        gate = '0;
        @(negedge clk);
        chk("midrst_env", 64'(env_out), 64'd0);
        chk("midrst_active", 64'(voice_active), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_fdone", 64'(frame_done), 64'd0);
        rst = 1'b0;
        model_reset();
        set_gate(4'b0001);
        n = 0;
        while (busy !== 1'b1 && n < 4 * DIV) begin
            @(negedge clk);
            n++;
        end
        chk("post_rst_latency", 64'(n), 64'(DIV));
        chk("post_rst_slot0_before", 64'(env_out[0 +: EW]), 64'd0);
        @(negedge clk);
        chk("post_rst_slot0_after", 64'(env_out[0 +: EW]), 64'h1FFF_FFFF);
        n = 0;
        while (busy === 1'b1 && n < 4 * NV) begin
            @(negedge clk);
            n++;
        end
        chk("post_rst_fdone", 64'(frame_done), 64'd1);
        model_sweep();
        compare_all("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
